// File: rtl/vram_pkg.sv
// vram_pkg: shared geometry, widths and types for the text-mode VRAM write path.
// Holds the 20x15 screen geometry, the fill FSM state type and the write-entry struct.
package vram_pkg;
  localparam int COLS       = 20;
  localparam int ROWS       = 15;
  localparam int VRAM_CELLS = COLS * ROWS;
  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 8;

  typedef enum logic [1:0] {
    FILL_IDLE,
    FILL_RUN,
    FILL_DONE
  } fill_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } vram_wr_t;
endpackage

// File: rtl/vram_write_sched_if.sv
// vram_write_sched_if: CPU single-cell write handshake into the VRAM scheduler.
// Signals: cpu_valid/cpu_ready handshake, cpu_adrs/cpu_data payload, cpu_err drop pulse.
interface vram_write_sched_if;
  import vram_pkg::*;

  logic              cpu_valid;
  logic              cpu_ready;
  logic [ADDR_W-1:0] cpu_adrs;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_err;

  modport master (
    output cpu_valid, cpu_adrs, cpu_data,
    input  cpu_ready, cpu_err
  );

  modport slave (
    input  cpu_valid, cpu_adrs, cpu_data,
    output cpu_ready, cpu_err
  );
endinterface

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo: small synchronous FIFO of vram_wr_t entries for buffered CPU writes.
// Ports: clk_pixel, resetn, push/wr in, pop in, head out, full/empty flags (state-only).
module vram_wr_fifo
  import vram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk_pixel,
  input  logic     resetn,
  input  logic     push,
  input  vram_wr_t wr,
  input  logic     pop,
  output vram_wr_t head,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);

  // Extra pointer bit separates full from empty.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  vram_wr_t    mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr;
  end
endmodule

// File: rtl/vram_write_sched.sv
// vram_write_sched: shares the VRAM write port between buffered CPU writes and a row fill engine.
// Ports: clk_pixel, resetn, cpu (slave if), fill_* request/status, vidAdrs/vidData/vidWE.
// Macro VRAM_CPU_PRIORITY_EN: CPU FIFO always wins; otherwise round-robin.
module vram_write_sched
  import vram_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk_pixel,
  input  logic               resetn,
  vram_write_sched_if.slave  cpu,
  input  logic               fill_start,
  input  logic [DATA_W-1:0]  fill_char,
  input  logic [3:0]         fill_row_first,
  input  logic [3:0]         fill_row_last,
  output logic               fill_busy,
  output logic               fill_done,
  output logic [ADDR_W-1:0]  vidAdrs,
  output logic [DATA_W-1:0]  vidData,
  output logic               vidWE
);
  logic        full;
  logic        empty;
  logic        accept;
  logic        in_range;
  logic        push;
  logic        gnt_cpu;
  logic        gnt_fill;
  logic        cpu_req;
  logic        fill_req;
  vram_wr_t    wr;
  vram_wr_t    head;

  fill_state_e       state;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] last_adr;
  logic [DATA_W-1:0] chr;
  logic [3:0]        row_last_c;
  logic [ADDR_W-1:0] start_adr;
  logic [ADDR_W-1:0] end_adr;

  // Ready comes from the stored full flag only.
  assign cpu.cpu_ready = !full;
  assign accept   = cpu.cpu_valid && !full;
  assign in_range = cpu.cpu_adrs < ADDR_W'(VRAM_CELLS);
  assign push     = accept && in_range;
  assign wr       = '{addr: cpu.cpu_adrs, data: cpu.cpu_data};

  vram_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_pixel (clk_pixel),
    .resetn    (resetn),
    .push      (push),
    .wr        (wr),
    .pop       (gnt_cpu),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) cpu.cpu_err <= 1'b0;
    else         cpu.cpu_err <= accept && !in_range;
  end

  assign cpu_req  = !empty;
  assign fill_req = (state == FILL_RUN);

`ifdef VRAM_CPU_PRIORITY_EN
  assign gnt_cpu  = cpu_req;
  assign gnt_fill = fill_req && !cpu_req;
`else
  // last_fill: fill won the most recent contended cycle.
  logic last_fill;

  assign gnt_cpu  = cpu_req && (!fill_req || last_fill);
  assign gnt_fill = fill_req && (!cpu_req || !last_fill);

  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn)                  last_fill <= 1'b0;
    else if (cpu_req && fill_req) last_fill <= !last_fill;
  end
`endif

  assign row_last_c = (fill_row_last > 4'(ROWS-1)) ? 4'(ROWS-1)
                                                   : fill_row_last;
  assign start_adr  = ADDR_W'(fill_row_first) * ADDR_W'(COLS);
  assign end_adr    = (ADDR_W'(row_last_c) + ADDR_W'(1)) * ADDR_W'(COLS)
                    - ADDR_W'(1);

  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      state     <= FILL_IDLE;
      cur       <= '0;
      last_adr  <= '0;
      chr       <= '0;
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      unique case (state)
        FILL_IDLE: begin
          fill_done <= 1'b0;
          if (fill_start) begin
            chr       <= fill_char;
            cur       <= start_adr;
            last_adr  <= end_adr;
            fill_busy <= 1'b1;
            if (fill_row_first > row_last_c) begin
              state     <= FILL_DONE;
              fill_done <= 1'b1;
            end else begin
              state <= FILL_RUN;
            end
          end
        end
        FILL_RUN: begin
          if (gnt_fill) begin
            cur <= cur + ADDR_W'(1);
            if (cur == last_adr) begin
              state     <= FILL_DONE;
              fill_done <= 1'b1;
            end
          end
        end
        FILL_DONE: begin
          state     <= FILL_IDLE;
          fill_busy <= 1'b0;
          fill_done <= 1'b0;
        end
        default: state <= FILL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      vidAdrs <= '0;
      vidData <= '0;
      vidWE   <= 1'b0;
    end else begin
      vidWE <= gnt_cpu || gnt_fill;
      unique case (1'b1)
        gnt_cpu: begin
          vidAdrs <= head.addr;
          vidData <= head.data;
        end
        gnt_fill: begin
          vidAdrs <= cur;
          vidData <= chr;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_vram_write_sched.sv
// tb_vram_write_sched: directed self-checking bench for vram_write_sched.
// Builds with or without VRAM_CPU_PRIORITY_EN; expected orderings follow the build.
module tb_vram_write_sched;
  import vram_pkg::*;

  logic              clk_pixel = 1'b0;
  logic              resetn;
  logic              fill_start;
  logic [7:0]        fill_char;
  logic [3:0]        fill_row_first;
  logic [3:0]        fill_row_last;
  logic              fill_busy;
  logic              fill_done;
  logic [8:0]        vidAdrs;
  logic [7:0]        vidData;
  logic              vidWE;

  vram_write_sched_if cpu_if ();

  vram_write_sched #(.FIFO_DEPTH(4)) dut (
    .clk_pixel      (clk_pixel),
    .resetn         (resetn),
    .cpu            (cpu_if),
    .fill_start     (fill_start),
    .fill_char      (fill_char),
    .fill_row_first (fill_row_first),
    .fill_row_last  (fill_row_last),
    .fill_busy      (fill_busy),
    .fill_done      (fill_done),
    .vidAdrs        (vidAdrs),
    .vidData        (vidData),
    .vidWE          (vidWE)
  );

  always #5 clk_pixel = ~clk_pixel;

  int n_chk = 0;
  int n_err = 0;
  int stalls = 0;

  logic [16:0] wlog [$];
  int          busy_cnt = 0;
  int          done_cnt = 0;

  always @(negedge clk_pixel) begin
    if (vidWE)     wlog.push_back({vidAdrs, vidData});
    if (fill_busy) busy_cnt++;
    if (fill_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic cpu_send(input logic [8:0] a, input logic [7:0] d);
    int   guard;
    logic hs;
    guard = 0;
    cpu_if.cpu_valid = 1'b1;
    cpu_if.cpu_adrs  = a;
    cpu_if.cpu_data  = d;
    do begin
      hs = cpu_if.cpu_ready;
      if (!hs) stalls++;
      tick();
      guard++;
    end while (!hs && guard < 50);
    if (!hs) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic fill_go(input logic [7:0] c, input logic [3:0] f,
                         input logic [3:0] l);
    fill_char      = c;
    fill_row_first = f;
    fill_row_last  = l;
    fill_start     = 1'b1;
    tick();
    fill_start     = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int k;
    k = 0;
    while (!fill_done && k < lim) begin
      tick();
      k++;
    end
    chk("done_seen", 32'(fill_done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          base;
    int          b0;
    int          d0;
    int          bad;
    int          k;
    logic [16:0] exp_q [$];

    resetn           = 1'b0;
    cpu_if.cpu_valid = 1'b0;
    cpu_if.cpu_adrs  = '0;
    cpu_if.cpu_data  = '0;
    fill_start       = 1'b0;
    fill_char        = '0;
    fill_row_first   = '0;
    fill_row_last    = '0;
    repeat (2) @(posedge clk_pixel);
    #1;
    chk("rst_we",   32'(vidWE), 32'd0);
    chk("rst_adr",  32'(vidAdrs), 32'd0);
    chk("rst_dat",  32'(vidData), 32'd0);
    chk("rst_busy", 32'(fill_busy), 32'd0);
    chk("rst_done", 32'(fill_done), 32'd0);
    chk("rst_err",  32'(cpu_if.cpu_err), 32'd0);
    @(negedge clk_pixel);
    resetn = 1'b1;
    tick();
    chk("rdy_after_rst", 32'(cpu_if.cpu_ready), 32'd1);

    // single CPU write, two-cycle latency
    cpu_if.cpu_valid = 1'b1;
    cpu_if.cpu_adrs  = 9'd5;
    cpu_if.cpu_data  = 8'h41;
    tick();
    cpu_if.cpu_valid = 1'b0;
    chk("lat1_we", 32'(vidWE), 32'd0);
    tick();
    chk("lat2_we",  32'(vidWE), 32'd1);
    chk("lat2_adr", 32'(vidAdrs), 32'd5);
    chk("lat2_dat", 32'(vidData), 32'h41);
    tick();
    chk("we_drop",  32'(vidWE), 32'd0);
    chk("adr_hold", 32'(vidAdrs), 32'd5);

    // full-screen clear
    base = wlog.size();
    b0   = busy_cnt;
    d0   = done_cnt;
    fill_go(8'h20, 4'd0, 4'd14);
    wait_done(400);
    tick();
    tick();
    chk("cls_cnt", 32'(wlog.size() - base), 32'd300);
    bad = 0;
    for (int i = 0; i < 300; i++)
      if (base + i >= wlog.size() || wlog[base+i] !== {9'(i), 8'h20})
        bad++;
    chk("cls_addr", 32'(bad), 32'd0);
    chk("cls_busy", 32'(busy_cnt - b0), 32'd301);
    chk("cls_done", 32'(done_cnt - d0), 32'd1);
    chk("cls_idle", 32'(fill_busy), 32'd0);

    // row 2 fill against a saturating CPU stream
    base   = wlog.size();
    d0     = done_cnt;
    stalls = 0;
    fork
      fill_go(8'h2A, 4'd2, 4'd2);
      begin
        for (int i = 0; i < 24; i++)
          cpu_send(9'(100 + i), 8'(8'h60 + i));
        cpu_if.cpu_valid = 1'b0;
      end
    join
    repeat (40) tick();
    exp_q.delete();
`ifdef VRAM_CPU_PRIORITY_EN
    for (int i = 0; i < 24; i++) exp_q.push_back({9'(100 + i), 8'(8'h60 + i)});
    for (int i = 0; i < 20; i++) exp_q.push_back({9'(40 + i), 8'h2A});
    chk("sat_stalls", 32'(stalls), 32'd0);
`else
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back({9'(40 + i), 8'h2A});
      exp_q.push_back({9'(100 + i), 8'(8'h60 + i)});
    end
    for (int i = 20; i < 24; i++) exp_q.push_back({9'(100 + i), 8'(8'h60 + i)});
    chk("sat_stalled", 32'(stalls > 0), 32'd1);
`endif
    chk("sat_cnt", 32'(wlog.size() - base), 32'd44);
    bad = 0;
    for (int i = 0; i < 44; i++)
      if (base + i >= wlog.size() || wlog[base+i] !== exp_q[i]) bad++;
    chk("sat_order", 32'(bad), 32'd0);
    chk("sat_done", 32'(done_cnt - d0), 32'd1);

    // out-of-range drop, then the last valid cell
    base = wlog.size();
    cpu_if.cpu_valid = 1'b1;
    cpu_if.cpu_adrs  = 9'd300;
    cpu_if.cpu_data  = 8'h55;
    tick();
    cpu_if.cpu_valid = 1'b0;
    chk("oor_err",  32'(cpu_if.cpu_err), 32'd1);
    tick();
    chk("oor_err0", 32'(cpu_if.cpu_err), 32'd0);
    chk("oor_we",   32'(wlog.size() - base), 32'd0);
    cpu_if.cpu_valid = 1'b1;
    cpu_if.cpu_adrs  = 9'd299;
    cpu_if.cpu_data  = 8'h7E;
    tick();
    cpu_if.cpu_valid = 1'b0;
    chk("c299_err", 32'(cpu_if.cpu_err), 32'd0);
    tick();
    chk("c299_we",  32'(vidWE), 32'd1);
    chk("c299_adr", 32'(vidAdrs), 32'd299);
    tick();

    // inverted row range: done with no writes
    base = wlog.size();
    fill_go(8'h11, 4'd10, 4'd3);
    chk("inv_busy", 32'(fill_busy), 32'd1);
    chk("inv_done", 32'(fill_done), 32'd1);
    tick();
    chk("inv_busy0", 32'(fill_busy), 32'd0);
    chk("inv_done0", 32'(fill_done), 32'd0);
    tick();
    chk("inv_nowr", 32'(wlog.size() - base), 32'd0);

    // last row beyond the screen is clamped
    base = wlog.size();
    fill_go(8'h33, 4'd14, 4'd15);
    wait_done(60);
    tick();
    chk("clamp_cnt",   32'(wlog.size() - base), 32'd20);
    chk("clamp_first", 32'(wlog[base][16:8]), 32'd280);
    chk("clamp_last",  32'(wlog[wlog.size()-1][16:8]), 32'd299);

    // reset in the middle of a fill
    d0 = done_cnt;
    fill_go(8'h44, 4'd0, 4'd14);
    k = 0;
    while (!(vidWE && vidAdrs == 9'd100) && k < 200) begin
      tick();
      k++;
    end
    chk("mid_reach100", 32'(vidWE && vidAdrs == 9'd100), 32'd1);
    resetn = 1'b0;
    #1;
    chk("mid_we",   32'(vidWE), 32'd0);
    chk("mid_busy", 32'(fill_busy), 32'd0);
    repeat (3) @(posedge clk_pixel);
    @(negedge clk_pixel);
    resetn = 1'b1;
    tick();
    chk("mid_nodone", 32'(done_cnt - d0), 32'd0);
    base = wlog.size();
    fill_go(8'h45, 4'd1, 4'd1);
    wait_done(60);
    tick();
    chk("post_cnt",   32'(wlog.size() - base), 32'd20);
    chk("post_first", 32'(wlog[base]), 32'({9'd20, 8'h45}));
    chk("post_last",  32'(wlog[wlog.size()-1][16:8]), 32'd39);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
